// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath widths and address type
package cpu_pkg;

   localparam int ADDR_W = 8;

   typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - loadable incrementing program counter
// Priority each edge: reset, then load, then inc, otherwise hold.
module program_counter
   import cpu_pkg::*;
#(
   parameter int          WIDTH     = ADDR_W,
   parameter int unsigned RESET_VAL = 0,
   parameter int unsigned STEP      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   input  logic             inc,
   output logic [WIDTH-1:0] data_out
);

   // Parameters are truncated to the counter width; sums wrap modulo 2^WIDTH.
   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_next;

   always_comb begin
      count_next = count;
      if (load) begin
         count_next = data_in;
      end else if (inc) begin
         count_next = count + STEP_V;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= RESET_V;
      end else begin
         count <= count_next;
      end
   end

   assign data_out = count;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - self-checking bench for program_counter
module tb_program_counter;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic       load;
   logic       inc;
   logic [7:0] data_out;

   int total;
   int bad;

   typedef struct {
      logic       rst;
      logic       ld;
      logic       up;
      logic [7:0] din;
      logic [7:0] want;
   } vec_t;

   vec_t vecs[12];

   program_counter #(
      .WIDTH(8),
      .RESET_VAL(0),
      .STEP(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .load(load),
      .inc(inc),
      .data_out(data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic r, input logic l, input logic i, input logic [7:0] d);
      @(negedge clk);
      reset   = r;
      load    = l;
      inc     = i;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   initial begin
      logic [7:0] held;
      int         model;
      logic       r;
      logic       l;
      logic       i;
      logic [7:0] d;

      total   = 0;
      bad     = 0;
      reset   = 1'b0;
      load    = 1'b0;
      inc     = 1'b0;
      data_in = 8'h00;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'hAA, 8'h00};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h55, 8'h00};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h05, 8'h05};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h06};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'hFE, 8'hFE};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hFF};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h01};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h40, 8'h40};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h41};

      for (int k = 0; k < 12; k++) begin
         step(vecs[k].rst, vecs[k].ld, vecs[k].up, vecs[k].din);
         check($sformatf("vec%0d", k), data_out, vecs[k].want);
      end

      // reset beats a simultaneous load and inc
      step(1'b1, 1'b1, 1'b1, 8'h99);
      check("reset_wins", data_out, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h99);
      check("after_reset_idle", data_out, 8'h00);

      // data_in is don't-care while idle, even when X
      step(1'b0, 1'b1, 1'b0, 8'h5A);
      held = data_out;
      check("load_5a", data_out, 8'h5A);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 1'b0, (k % 3 == 0) ? 8'hxx : 8'($urandom));
         check($sformatf("idle_hold%0d", k), data_out, held);
      end

      // inc held high for N edges advances by N
      step(1'b0, 1'b1, 1'b0, 8'hF0);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
      check("inc_run20", data_out, 8'h04);

      // randomized traffic against a modulo-256 reference
      step(1'b1, 1'b0, 1'b0, 8'h00);
      model = 0;
      for (int k = 0; k < 300; k++) begin
         r = ($urandom_range(0, 19) == 0);
         l = ($urandom_range(0, 3) == 0);
         i = $urandom_range(0, 1);
         d = 8'($urandom);
         step(r, l, i, d);
         if (r)      model = 0;
         else if (l) model = int'(d);
         else if (i) model = (model + 1) % 256;
         check($sformatf("rand%0d", k), data_out, 8'(model));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
